// File: rtl/err_window_alarm_if.sv
// rtl/err_window_alarm_if.sv - monitor-side signal bundle for err_window_alarm
interface err_window_alarm_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             ERR;
    logic             ack;
    logic             ALARM;
    logic [8:0]       win_err;
    logic [7:0]       win_pos;
    logic [CNT_W-1:0] alarm_cnt;
    logic [CNT_W-1:0] total_err;

    modport master (
        output en, ERR, ack,
        input  ALARM, win_err, win_pos, alarm_cnt, total_err
    );

    modport slave (
        input  en, ERR, ack,
        output ALARM, win_err, win_pos, alarm_cnt, total_err
    );
endinterface

// File: rtl/err_window_alarm.sv
// rtl/err_window_alarm.sv - windowed ERR pulse counter with latched, acknowledged ALARM
// Optional total ERR counter built when ERR_TOTAL_CNT_EN is defined.
module err_window_alarm #(
    parameter int WIN_LEN = 16,
    parameter int THRESH  = 3,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    err_window_alarm_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_MONITOR = 2'b01;
    localparam logic [1:0] S_ALRM    = 2'b10;

    localparam logic [8:0]       THR      = 9'(THRESH);
    localparam logic [7:0]       LAST_POS = 8'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic             alarm_q;
    logic [8:0]       win_err_q;
    logic [7:0]       win_pos_q;
    logic [CNT_W-1:0] alarm_cnt_q;
    logic [8:0]       hit;

    assign hit = win_err_q + {8'd0, bus.ERR};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            alarm_q     <= 1'b0;
            win_err_q   <= 9'd0;
            win_pos_q   <= 8'd0;
            alarm_cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    win_err_q <= 9'd0;
                    win_pos_q <= 8'd0;
                    if (bus.en) state <= S_MONITOR;
                end
                S_MONITOR: begin
                    if (!bus.en) begin
                        state     <= S_IDLE;
                        win_err_q <= 9'd0;
                        win_pos_q <= 8'd0;
                    end else if (hit == THR) begin
                        // Threshold beats end-of-window so a last-cycle ERR still alarms.
                        state     <= S_ALRM;
                        alarm_q   <= 1'b1;
                        win_err_q <= THR;
                        if (alarm_cnt_q != CNT_MAX) alarm_cnt_q <= alarm_cnt_q + CNT_ONE;
                    end else if (win_pos_q == LAST_POS) begin
                        win_err_q <= 9'd0;
                        win_pos_q <= 8'd0;
                    end else begin
                        win_err_q <= hit;
                        win_pos_q <= win_pos_q + 8'd1;
                    end
                end
                S_ALRM: begin
                    if (bus.ack) begin
                        alarm_q   <= 1'b0;
                        win_err_q <= 9'd0;
                        win_pos_q <= 8'd0;
                        state     <= bus.en ? S_MONITOR : S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    alarm_q   <= 1'b0;
                    win_err_q <= 9'd0;
                    win_pos_q <= 8'd0;
                end
            endcase
        end
    end

    assign bus.ALARM     = alarm_q;
    assign bus.win_err   = win_err_q;
    assign bus.win_pos   = win_pos_q;
    assign bus.alarm_cnt = alarm_cnt_q;

`ifdef ERR_TOTAL_CNT_EN
    logic [CNT_W-1:0] total_err_q;

    // Counts regardless of state, so IDLE and ALRM pulses are not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_err_q <= '0;
        end else if (bus.ERR && total_err_q != CNT_MAX) begin
            total_err_q <= total_err_q + CNT_ONE;
        end
    end

    assign bus.total_err = total_err_q;
`else
    assign bus.total_err = '0;
`endif
endmodule

// File: tb/tb_err_window_alarm.sv
// tb/tb_err_window_alarm.sv - directed self-checking bench for err_window_alarm
module tb_err_window_alarm;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   tot;

    err_window_alarm_if #(.CNT_W(8)) bus ();

    err_window_alarm #(.WIN_LEN(16), .THRESH(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int alarm, input int werr,
                             input int wpos, input int acnt);
        chk({tag, ".ALARM"},     32'(bus.ALARM),     32'(alarm));
        chk({tag, ".win_err"},   32'(bus.win_err),   32'(werr));
        chk({tag, ".win_pos"},   32'(bus.win_pos),   32'(wpos));
        chk({tag, ".alarm_cnt"}, 32'(bus.alarm_cnt), 32'(acnt));
        chk({tag, ".total_err"}, 32'(bus.total_err), 32'(tot));
    endtask

    // One clock with the given inputs; the total_err model advances alongside.
    task automatic step(input logic r, input logic e, input logic x, input logic a);
        rst     = r;
        bus.en  = e;
        bus.ERR = x;
        bus.ack = a;
        @(posedge clk);
        #1;
`ifdef ERR_TOTAL_CNT_EN
        if (r) tot = 0;
        else if (x && tot < 255) tot++;
`else
        tot = 0;
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        tot   = 0;
        rst = 1'b1; bus.en = 1'b0; bus.ERR = 1'b0; bus.ack = 1'b0;

        // 1: reset dominates en and ERR
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        check_all("reset", 0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_all("idle", 0, 0, 0, 0);

        // 2: alarm at positions 2,5,9; ERR on the IDLE->MONITOR cycle is not windowed
        step(0, 1, 1, 0);
        check_all("enter", 0, 0, 0, 0);
        for (int p = 0; p <= 5; p++) step(0, 1, (p == 2 || p == 5), 0);
        check_all("mid_win", 0, 2, 6, 0);
        for (int p = 6; p <= 9; p++) step(0, 1, (p == 9), 0);
        check_all("alarm1", 1, 3, 9, 1);

        // 5: ALARM held, ERR ignored, then ack together with ERR
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
        check_all("hold", 1, 3, 9, 1);
        step(0, 1, 1, 1);
        check_all("ack1", 0, 0, 0, 1);

        // 3: two pulses per window never alarm; window end clears
        for (int p = 0; p <= 14; p++) step(0, 1, (p == 3 || p == 14), 0);
        check_all("pos15", 0, 2, 15, 1);
        step(0, 1, 0, 0);
        check_all("wrap", 0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        check_all("next_win", 0, 1, 2, 1);
        for (int p = 2; p <= 15; p++) step(0, 1, 0, 0);
        check_all("wrap2", 0, 0, 0, 1);

        // 4: third pulse on the last window cycle alarms without wrapping
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        check_all("two_early", 0, 2, 2, 1);
        for (int p = 2; p <= 14; p++) step(0, 1, 0, 0);
        check_all("pre_last", 0, 2, 15, 1);
        step(0, 1, 1, 0);
        check_all("alarm_last", 1, 3, 15, 2);
        step(0, 1, 1, 0);
        check_all("frozen", 1, 3, 15, 2);
        step(0, 1, 0, 1);
        check_all("ack2", 0, 0, 0, 2);

        // 6: disable mid-window discards it; IDLE saturates total; reset in ALRM
        for (int p = 0; p <= 6; p++) step(0, 1, (p == 1 || p == 4), 0);
        check_all("pre_dis", 0, 2, 7, 2);
        step(0, 0, 1, 0);
        check_all("disable", 0, 0, 0, 2);
        for (int i = 0; i < 300; i++) step(0, 0, 1, 0);
        check_all("sat", 0, 0, 0, 2);
        step(0, 1, 0, 0);
        check_all("reenter", 0, 0, 0, 2);
        for (int p = 0; p <= 2; p++) step(0, 1, 1, 0);
        check_all("alarm3", 1, 3, 2, 3);
        step(1, 1, 1, 0);
        check_all("rst_alrm", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/err_window_alarm.md
Name: err_window_alarm

Overview:
- Downstream consumer of the 3-bit serial pattern monitor's ERR pulse.
- Counts ERR pulses inside fixed, back-to-back windows of WIN_LEN enabled cycles.
- Raises a latched ALARM when the count in one window reaches THRESH; ALARM holds until software/host acknowledges.
- Also keeps a saturating count of alarms raised, for status readback.

Parameters:
WIN_LEN, 16, window length in enabled clock cycles (legal 2..256)
THRESH, 3, ERR pulses within one window that trigger ALARM (legal 1..WIN_LEN)
CNT_W, 8, width of alarm_cnt and total_err counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  monitoring enable
ERR  input  1  error pulse from pattern monitor, sampled every clk
ack  input  1  alarm acknowledge, level or pulse
ALARM  output  1  latched alarm flag
win_err  output  9  ERR count in current window
win_pos  output  8  cycle index within current window, 0..WIN_LEN-1
alarm_cnt  output  CNT_W  alarms raised since reset, saturating
total_err  output  CNT_W  total ERR pulses since reset, saturating (optional feature)

Behaviour:
- Reset behaviour:
  - rst=1 at a rising edge dominates every other input.
  - State goes to IDLE; ALARM, win_err, win_pos, alarm_cnt and total_err all go to 0.
  - A reset asserted mid-window or while in ALARM clears everything on that edge.
- All outputs are registered; every response appears one cycle after the sampled input.
- States (2-bit encoding): IDLE=00, MONITOR=01, ALRM=10; 11 falls back to IDLE.
- IDLE:
  - win_pos and win_err are held at 0; ERR is ignored for windowing.
  - en=1 moves to MONITOR. The first enabled cycle after that is window position 0.
- MONITOR, each cycle:
  - en=0: go to IDLE and clear win_pos and win_err. A partial window is discarded.
  - Otherwise compute hit = win_err + ERR.
  - If hit == THRESH: go to ALRM, ALARM<=1, win_err<=THRESH, win_pos frozen, alarm_cnt += 1 (saturates at 2^CNT_W-1).
  - Else if win_pos == WIN_LEN-1: end of window; win_pos<=0 and win_err<=0. The ERR on this last cycle counts toward this window, not the next.
  - Else: win_pos += 1; win_err <= hit.
- ALRM:
  - ALARM stays 1; win_err and win_pos are frozen; ERR does not affect the window counters.
  - ack=1: ALARM<=0 and win_pos, win_err <= 0. Next state is MONITOR if en=1, else IDLE. A new window starts the cycle after the ack edge.
  - ack and ERR in the same ALRM cycle: the ERR is discarded for windowing.
  - ack has no effect outside ALRM.
- ERR held high for k cycles counts as k errors.
- THRESH=1: a single ERR raises ALARM on the next edge.

Optional Feature:
- Macro: ERR_TOTAL_CNT_EN.
- Defined:
  - total_err increments on every cycle with ERR=1 and rst=0, in any state including IDLE and ALRM.
  - It saturates at 2^CNT_W-1 and never wraps.
- Undefined:
  - The counter is not built; total_err is tied to 0.
  - All other behaviour is unchanged.

Test Plan:
1. Reset check: hold rst=1 for 2 cycles with ERR=1 and en=1 -> ALARM=0, win_err=0, win_pos=0, alarm_cnt=0, total_err=0 on release.
2. Alarm within a window: en=1, ERR pulses at window positions 2, 5 and 9 -> ALARM=1 on the edge after position 9, win_err=3, win_pos frozen at 9, alarm_cnt=1.
3. Window boundary clearing: 2 pulses at positions 3 and 14, then 1 pulse at position 1 of the next window -> ALARM stays 0; win_err returns to 0 after position 15, then reads 1.
4. Error on the last window cycle: pulses at positions 0, 1 and 15 -> ALARM=1 after position 15; win_pos does not wrap.
5. Acknowledge: ALARM held for 5 cycles, with ERR=1 in the same cycle as an ack pulse -> ALARM=0 next cycle, win_err=0, win_pos=0, alarm_cnt stays 1. With ERR_TOTAL_CNT_EN defined, total_err includes the ack-cycle pulse.
6. Disable and reset mid-operation: en dropped at position 7 with win_err=2 -> IDLE, counters 0, no alarm. With the macro defined, 300 ERR cycles give total_err=255. rst asserted in ALRM clears all outputs on that edge.
